// File: rtl/uart_fifo16_rx.sv
// 8N1 UART transmitter/receiver with a 16-entry first-word-fall-through RX FIFO.
// Define UART_RX_OVERRUN_EN to add the sticky rx_overrun output.
module uart_fifo16_rx #(
   parameter int CLK_DIVIDER = 1302
) (
   input  logic       clk,
   input  logic       reset,
   output logic       serial_out,
   input  logic       serial_in,
   input  logic [7:0] write_data,
   input  logic       write_strobe,
   output logic       write_rdy,
   output logic [7:0] rd_data,
   output logic       rd_rdy,
   input  logic       rd_strobe,
   output logic       wr_rdy,
`ifdef UART_RX_OVERRUN_EN
   output logic       rx_overrun,
`endif
   output logic       halffull
);

   localparam int CW = $clog2(CLK_DIVIDER);

   typedef enum logic [1:0] {
      TX_IDLE, TX_START, TX_DATA, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
   } rx_state_e;

   tx_state_e      tx_state_q, tx_state_d;
   logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]     tx_bit_q, tx_bit_d;
   logic [7:0]     tx_shift_q, tx_shift_d;

   rx_state_e      rx_state_q, rx_state_d;
   logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_bit_q, rx_bit_d;
   logic [7:0]     rx_shift_q, rx_shift_d;
   logic [2:0]     sync_q, sync_d;
   logic           push_q, push_d;

   logic [7:0]     mem_q [16];
   logic [3:0]     wptr_q, wptr_d;
   logic [3:0]     rptr_q, rptr_d;
   logic [4:0]     cnt_q, cnt_d;
   logic           ovr_q, ovr_d;

   logic tx_last, rx_last, rx_half, rx_s, rx_prev;
   logic full, empty, do_push, do_pop;

   assign tx_last = tx_cnt_q == CW'(CLK_DIVIDER - 1);
   assign rx_last = rx_cnt_q == CW'(CLK_DIVIDER - 1);
   assign rx_half = rx_cnt_q == CW'(CLK_DIVIDER / 2 - 1);
   assign rx_s    = sync_q[1];
   assign rx_prev = sync_q[2];

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (write_strobe) begin
               tx_shift_d = write_data;
               tx_cnt_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            tx_cnt_d = tx_cnt_q + CW'(1);
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            tx_cnt_d = tx_cnt_q + CW'(1);
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            tx_cnt_d = tx_cnt_q + CW'(1);
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign write_rdy  = tx_state_q == TX_IDLE;
   assign serial_out = (tx_state_q == TX_START) ? 1'b0 :
                       (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;

   // Bit timer restarts on the falling edge; START checks the bit centre.
   always_comb begin
      sync_d     = {sync_q[1:0], serial_in};
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      push_d     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            rx_cnt_d = rx_cnt_q + CW'(1);
            if (rx_half) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            rx_cnt_d = rx_cnt_q + CW'(1);
            if (rx_last) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            rx_cnt_d = rx_cnt_q + CW'(1);
            if (rx_last) begin
               rx_cnt_d   = '0;
               push_d     = rx_s;
               rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
            end
         end
         RX_BREAK: begin
            if (rx_s) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Full is judged before any same-cycle pop.
   assign full    = cnt_q == 5'd16;
   assign empty   = cnt_q == 5'd0;
   assign do_push = push_q && !full;
   assign do_pop  = rd_strobe && !empty;

   always_comb begin
      wptr_d = wptr_q + {3'b0, do_push};
      rptr_d = rptr_q + {3'b0, do_pop};
      cnt_d  = cnt_q + {4'b0, do_push} - {4'b0, do_pop};
      ovr_d  = ovr_q;
      if (push_q && full) ovr_d = 1'b1;
      else if (do_pop)    ovr_d = 1'b0;
   end

   assign rd_data  = empty ? 8'h00 : mem_q[rptr_q];
   assign rd_rdy   = !empty;
   assign wr_rdy   = !full;
   assign halffull = cnt_q >= 5'd8;
`ifdef UART_RX_OVERRUN_EN
   assign rx_overrun = ovr_q;
`endif

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= rx_shift_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         sync_q     <= 3'b111;
         push_q     <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         ovr_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         sync_q     <= sync_d;
         push_q     <= push_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         ovr_q      <= ovr_d;
      end
   end

endmodule

// File: tb/tb_uart_fifo16_rx.sv
// Bench for uart_fifo16_rx: randomized frames checked against a queue model.
// Honours UART_RX_OVERRUN_EN when defined.
module tb_uart_fifo16_rx;

   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       serial_out;
   logic       serial_in;
   logic [7:0] write_data;
   logic       write_strobe;
   logic       write_rdy;
   logic [7:0] rd_data;
   logic       rd_rdy;
   logic       rd_strobe;
   logic       wr_rdy;
   logic       halffull;
`ifdef UART_RX_OVERRUN_EN
   logic       rx_overrun;
`endif

   int vec = 0;
   int bad = 0;
   logic [7:0] q[$];
   logic ovr_m = 1'b0;

   uart_fifo16_rx #(.CLK_DIVIDER(DIV)) dut (
      .clk(clk),
      .reset(reset),
      .serial_out(serial_out),
      .serial_in(serial_in),
      .write_data(write_data),
      .write_strobe(write_strobe),
      .write_rdy(write_rdy),
      .rd_data(rd_data),
      .rd_rdy(rd_rdy),
      .rd_strobe(rd_strobe),
      .wr_rdy(wr_rdy),
`ifdef UART_RX_OVERRUN_EN
      .rx_overrun(rx_overrun),
`endif
      .halffull(halffull)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] exp_flags();
      return {q.size() != 0, q.size() != 16, q.size() >= 8};
   endfunction

   task automatic model_push(input logic [7:0] b);
      if (q.size() < 16) q.push_back(b);
      else ovr_m = 1'b1;
   endtask

   task automatic model_pop();
      if (q.size() != 0) begin
         void'(q.pop_front());
         ovr_m = 1'b0;
      end
   endtask

   // Drives one 8N1 frame; optionally pops the FIFO at loop index pop_at.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int pop_at, output logic [7:0] got,
                             output logic got_rdy);
      logic [9:0] fb;
      fb = {stop, b, 1'b0};
      got = 8'h00;
      got_rdy = 1'b0;
      for (int i = 0; i < 10 * DIV; i++) begin
         @(negedge clk);
         serial_in = fb[i / DIV];
         if (i == pop_at) begin
            got = rd_data;
            got_rdy = rd_rdy;
            rd_strobe = 1'b1;
         end
         if (i == pop_at + 1) rd_strobe = 1'b0;
      end
      @(negedge clk);
      serial_in = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_one(output logic [7:0] got, output logic got_rdy);
      @(negedge clk);
      got = rd_data;
      got_rdy = rd_rdy;
      rd_strobe = 1'b1;
      @(negedge clk);
      rd_strobe = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vec++;
      if ({serial_out, write_rdy} !== 2'b11) begin
         bad++;
         $display("FAIL reset_tx: got %b want 11", {serial_out, write_rdy});
      end
      vec++;
      if ({rd_rdy, wr_rdy, halffull} !== 3'b010 || rd_data !== 8'h00) begin
         bad++;
         $display("FAIL reset_fifo: flags %b data %h want 010 00",
                  {rd_rdy, wr_rdy, halffull}, rd_data);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vec++;
      if ({serial_out, write_rdy, rd_rdy, wr_rdy, halffull} !== 5'b11010) begin
         bad++;
         $display("FAIL reset_release: got %b want 11010",
                  {serial_out, write_rdy, rd_rdy, wr_rdy, halffull});
      end
`ifdef UART_RX_OVERRUN_EN
      vec++;
      if (rx_overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_ovr: got %b want 0", rx_overrun);
      end
`endif
   endtask

   task automatic test_tx();
      logic [7:0] b;
      logic [9:0] fb;
      logic ok;
      for (int f = 0; f < 3; f++) begin
         b = (f == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         fb = {1'b1, b, 1'b0};
         @(negedge clk);
         vec++;
         if (write_rdy !== 1'b1) begin
            bad++;
            $display("FAIL tx_idle_rdy: got %b want 1", write_rdy);
         end
         write_data = b;
         write_strobe = 1'b1;
         ok = 1'b1;
         for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            if (serial_out !== fb[i / DIV] || write_rdy !== 1'b0) ok = 1'b0;
            if (i == 0) write_strobe = 1'b0;
            if (f == 0 && i == 50) begin
               write_data = ~b;
               write_strobe = 1'b1;
            end
            if (f == 0 && i == 51) write_strobe = 1'b0;
            if (i % DIV == DIV - 1) begin
               vec++;
               if (!ok) begin
                  bad++;
                  $display("FAIL tx_bit%0d: byte %h out %b rdy %b want %b 0",
                           i / DIV, b, serial_out, write_rdy, fb[i / DIV]);
               end
               ok = 1'b1;
            end
         end
         @(negedge clk);
         vec++;
         if ({write_rdy, serial_out} !== 2'b11) begin
            bad++;
            $display("FAIL tx_end: got %b want 11", {write_rdy, serial_out});
         end
      end
   endtask

   task automatic test_rx_single();
      logic [7:0] got;
      logic got_rdy;
      send_frame(8'h3C, 1'b1, -1, got, got_rdy);
      model_push(8'h3C);
      vec++;
      if (rd_rdy !== 1'b1 || rd_data !== q[0]) begin
         bad++;
         $display("FAIL rx_single: rdy %b data %h want 1 %h", rd_rdy, rd_data, q[0]);
      end
      pop_one(got, got_rdy);
      model_pop();
      vec++;
      if (rd_rdy !== 1'b0) begin
         bad++;
         $display("FAIL rx_single_pop: rd_rdy %b want 0", rd_rdy);
      end
   endtask

   task automatic test_false_start();
      logic [7:0] got;
      logic got_rdy;
      @(negedge clk);
      serial_in = 1'b0;
      repeat (8) @(negedge clk);
      serial_in = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      vec++;
      if ({rd_rdy, wr_rdy, halffull} !== exp_flags()) begin
         bad++;
         $display("FAIL glitch: flags %b want %b", {rd_rdy, wr_rdy, halffull}, exp_flags());
      end
      send_frame(8'h55, 1'b0, -1, got, got_rdy);
      repeat (DIV) @(negedge clk);
      vec++;
      if ({rd_rdy, wr_rdy, halffull} !== exp_flags()) begin
         bad++;
         $display("FAIL framing: flags %b want %b", {rd_rdy, wr_rdy, halffull}, exp_flags());
      end
      send_frame(8'h12, 1'b1, -1, got, got_rdy);
      model_push(8'h12);
      vec++;
      if (rd_rdy !== 1'b1 || rd_data !== q[0]) begin
         bad++;
         $display("FAIL after_framing: rdy %b data %h want 1 %h", rd_rdy, rd_data, q[0]);
      end
      pop_one(got, got_rdy);
      model_pop();
   endtask

   task automatic test_fifo_fill();
      logic [7:0] got;
      logic got_rdy;
      logic [7:0] want;
      for (int k = 0; k < 17; k++) begin
         want = (k == 16) ? 8'hFF : 8'(k);
         send_frame(want, 1'b1, -1, got, got_rdy);
         model_push(want);
         vec++;
         if ({rd_rdy, wr_rdy, halffull} !== exp_flags() || rd_data !== q[0]) begin
            bad++;
            $display("FAIL fill_%0d: flags %b data %h want %b %h", k,
                     {rd_rdy, wr_rdy, halffull}, rd_data, exp_flags(), q[0]);
         end
      end
`ifdef UART_RX_OVERRUN_EN
      vec++;
      if (rx_overrun !== ovr_m) begin
         bad++;
         $display("FAIL fill_ovr: got %b want %b", rx_overrun, ovr_m);
      end
`endif
      while (q.size() != 0) begin
         want = q[0];
         pop_one(got, got_rdy);
         model_pop();
         vec++;
         if (got_rdy !== 1'b1 || got !== want) begin
            bad++;
            $display("FAIL drain: rdy %b data %h want 1 %h", got_rdy, got, want);
         end
`ifdef UART_RX_OVERRUN_EN
         vec++;
         if (rx_overrun !== ovr_m) begin
            bad++;
            $display("FAIL drain_ovr: got %b want %b", rx_overrun, ovr_m);
         end
`endif
      end
      @(negedge clk);
      vec++;
      if (rd_rdy !== 1'b0) begin
         bad++;
         $display("FAIL drain_empty: rd_rdy %b want 0", rd_rdy);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] got;
      logic got_rdy;
      logic [7:0] b;
      logic [7:0] want;
      for (int k = 0; k < 5; k++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b1, -1, got, got_rdy);
         model_push(b);
      end
      for (int k = 0; k < 14; k++) begin
         b = 8'($urandom_range(0, 255));
         want = q[0];
         send_frame(b, 1'b1, 155, got, got_rdy);
         model_pop();
         model_push(b);
         vec++;
         if (got_rdy !== 1'b1 || got !== want ||
             {rd_rdy, wr_rdy, halffull} !== exp_flags() || rd_data !== q[0]) begin
            bad++;
            $display("FAIL wrap_%0d: pop %h flags %b head %h want %h %b %h", k,
                     got, {rd_rdy, wr_rdy, halffull}, rd_data, want, exp_flags(), q[0]);
         end
      end
      while (q.size() != 0) begin
         want = q[0];
         pop_one(got, got_rdy);
         model_pop();
         vec++;
         if (got_rdy !== 1'b1 || got !== want) begin
            bad++;
            $display("FAIL wrap_drain: rdy %b data %h want 1 %h", got_rdy, got, want);
         end
      end
   endtask

   task automatic test_full_concurrent();
      logic [7:0] got;
      logic got_rdy;
      logic [7:0] b;
      logic [7:0] want;
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b1, -1, got, got_rdy);
         model_push(b);
      end
      want = q[0];
      send_frame(8'hEE, 1'b1, 155, got, got_rdy);
      model_push(8'hEE);
      model_pop();
      ovr_m = 1'b1;
      vec++;
      if (got_rdy !== 1'b1 || got !== want ||
          {rd_rdy, wr_rdy, halffull} !== exp_flags()) begin
         bad++;
         $display("FAIL full_pushpop: pop %h flags %b want %h %b",
                  got, {rd_rdy, wr_rdy, halffull}, want, exp_flags());
      end
`ifdef UART_RX_OVERRUN_EN
      vec++;
      if (rx_overrun !== ovr_m) begin
         bad++;
         $display("FAIL full_ovr: got %b want %b", rx_overrun, ovr_m);
      end
`endif
      while (q.size() != 0) begin
         want = q[0];
         pop_one(got, got_rdy);
         model_pop();
         vec++;
         if (got_rdy !== 1'b1 || got !== want) begin
            bad++;
            $display("FAIL full_drain: rdy %b data %h want 1 %h", got_rdy, got, want);
         end
      end
      ovr_m = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [7:0] got;
      logic got_rdy;
      logic [7:0] b;
      for (int k = 0; k < 3; k++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b1, -1, got, got_rdy);
         model_push(b);
      end
      @(negedge clk);
      write_data = 8'h5A;
      write_strobe = 1'b1;
      serial_in = 1'b0;
      @(negedge clk);
      write_strobe = 1'b0;
      repeat (40) @(negedge clk);
      vec++;
      if ({write_rdy, rd_rdy} !== 2'b01) begin
         bad++;
         $display("FAIL pre_reset: got %b want 01", {write_rdy, rd_rdy});
      end
      #1;
      reset = 1'b0;
      #1;
      q.delete();
      ovr_m = 1'b0;
      vec++;
      if ({serial_out, write_rdy, rd_rdy, wr_rdy, halffull} !== 5'b11010 ||
          rd_data !== 8'h00) begin
         bad++;
         $display("FAIL async_reset: got %b %h want 11010 00",
                  {serial_out, write_rdy, rd_rdy, wr_rdy, halffull}, rd_data);
      end
      @(negedge clk);
      serial_in = 1'b1;
      reset = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      vec++;
      if ({serial_out, write_rdy, rd_rdy, wr_rdy, halffull} !== 5'b11010) begin
         bad++;
         $display("FAIL post_reset: got %b want 11010",
                  {serial_out, write_rdy, rd_rdy, wr_rdy, halffull});
      end
   endtask

   initial begin
      reset = 1'b0;
      serial_in = 1'b1;
      write_data = 8'h00;
      write_strobe = 1'b0;
      rd_strobe = 1'b0;
      test_reset();
      test_tx();
      test_rx_single();
      test_false_start();
      test_fifo_fill();
      test_wrap();
      test_full_concurrent();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
